regs_wb_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order MemWB writeback and NREQ late-completion requesters, such as a multi-cycle divider and load-miss refill.
- Pipeline writeback has priority. Late requesters are served round-robin in idle write-port cycles.
- A starvation counter forces a one-cycle pipeline stall so that a waiting late requester is guaranteed to be served.
- Sits between the MemWB stage outputs and the register file write port. Its stall_out feeds the pipeline stall chain.

---
 rtl/regs_wb_arbiter.sv | 174 +++++++++++++++++
 tb/tb_regs_wb_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter
//   Shares the register-file write port between the in-order MemWB writeback
//   and NREQ late-completion requesters (divider, load-miss refill, ...).
//   The pipeline writeback has priority. Late requesters are served
//   round-robin in cycles where the port is otherwise free. A starvation
//   counter forces a one-cycle pipeline stall (FORCE state) so that a waiting
//   late requester is always served eventually.
//
// Ports
//   clk            clock, all logic on posedge
//   reset          synchronous, active-low reset
//   wb_write_in    MemWB writeback valid
//   wb_id_in       MemWB destination register index
//   wb_data_in     MemWB writeback data
//   req_valid_in   late request valid, one bit per requester
//   req_id_in      late destination indices, requester i at [32*i+31:32*i]
//   req_data_in    late data, same packing as req_id_in
//   req_ready_out  combinational grant, one-hot or zero
//   stall_out      registered; high during the FORCE cycle
//   regs_write_out register-file write enable (registered, latency 1)
//   regs_wr_id_out register-file write index (holds when no write)
//   regs_data_out  register-file write data (holds when no write)
//   err_out        sticky protocol-violation flag
module regs_wb_arbiter #(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_write_in,
  input  logic [31:0]        wb_id_in,
  input  logic [31:0]        wb_data_in,
  input  logic [NREQ-1:0]    req_valid_in,
  input  logic [NREQ*32-1:0] req_id_in,
  input  logic [NREQ*32-1:0] req_data_in,
  output logic [NREQ-1:0]    req_ready_out,
  output logic               stall_out,
  output logic               regs_write_out,
  output logic [31:0]        regs_wr_id_out,
  output logic [31:0]        regs_data_out,
  output logic               err_out
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              err_q, err_d;
  logic              regs_write_q, regs_write_d;
  logic [31:0]       regs_wr_id_q, regs_wr_id_d;
  logic [31:0]       regs_data_q, regs_data_d;

  logic              wb_wins;
  logic              grant_found;
  logic              late_grant;
  logic [PTR_W-1:0]  grant_idx;
  logic [PTR_W-1:0]  grant_next_ptr;
  logic [31:0]       grant_id;
  logic [31:0]       grant_data;
  logic [2*NREQ-1:0] valid_rot;

  // Round-robin scan. The valid vector is doubled and shifted down by
  // rr_ptr so that bit k of the result is requester (rr_ptr+k) mod NREQ;
  // this keeps every select index a loop constant.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    wb_wins     = (state_q == ST_NORMAL) && wb_write_in && (wb_id_in != '0);
    grant_found = 1'b0;
    grant_idx   = '0;
    valid_rot   = {req_valid_in, req_valid_in} >> rr_ptr_q;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!grant_found && valid_rot[k]) begin
        grant_found = 1'b1;
        idx         = (32'(rr_ptr_q) + k) % NREQ;
        grant_idx   = PTR_W'(idx);
      end
    end
    late_grant     = grant_found && !wb_wins;
    grant_next_ptr = PTR_W'((32'(grant_idx) + 1) % NREQ);
  end

  // Select the granted requester's id and data.
  always_comb begin
    grant_id   = '0;
    grant_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (PTR_W'(k) == grant_idx) begin
        grant_id   = req_id_in[32*k +: 32];
        grant_data = req_data_in[32*k +: 32];
      end
    end
  end

  // A grant is withheld while reset is low so an in-flight handshake cannot
  // complete without its write.
  always_comb begin
    req_ready_out = '0;
    if (late_grant && reset) begin
      req_ready_out = NREQ'(1) << grant_idx;
    end
  end

  always_comb begin
    state_d      = ST_NORMAL;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    err_d        = err_q;
    regs_write_d = 1'b0;
    regs_wr_id_d = regs_wr_id_q;
    regs_data_d  = regs_data_q;

    if (late_grant) begin
      rr_ptr_d     = grant_next_ptr;
      starve_cnt_d = '0;
      // Index 0 is accepted but never written.
      if (grant_id != '0) begin
        regs_write_d = 1'b1;
        regs_wr_id_d = grant_id;
        regs_data_d  = grant_data;
      end
    end else if (wb_wins) begin
      regs_write_d = 1'b1;
      regs_wr_id_d = wb_id_in;
      regs_data_d  = wb_data_in;
    end

    if (state_q == ST_FORCE) begin
      if (wb_write_in || !grant_found) begin
        err_d = 1'b1;
      end
    end else if (!late_grant && (req_valid_in != '0)) begin
      if (starve_cnt_q == 8'(STARVE_LIMIT - 1)) begin
        state_d      = ST_FORCE;
        starve_cnt_d = '0;
      end else begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_NORMAL;
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
      regs_write_q <= 1'b0;
      regs_wr_id_q <= '0;
      regs_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
      regs_write_q <= regs_write_d;
      regs_wr_id_q <= regs_wr_id_d;
      regs_data_q  <= regs_data_d;
    end
  end

  assign stall_out      = (state_q == ST_FORCE);
  assign regs_write_out = regs_write_q;
  assign regs_wr_id_out = regs_wr_id_q;
  assign regs_data_out  = regs_data_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_regs_wb_arbiter.sv
module tb_regs_wb_arbiter;
  localparam int NREQ = 2;
  localparam int LIM  = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               wb_write_in = 1'b0;
  logic [31:0]        wb_id_in = '0;
  logic [31:0]        wb_data_in = '0;
  logic [NREQ-1:0]    req_valid_in = '0;
  logic [NREQ*32-1:0] req_id_in = '0;
  logic [NREQ*32-1:0] req_data_in = '0;
  logic [NREQ-1:0]    req_ready_out;
  logic               stall_out;
  logic               regs_write_out;
  logic [31:0]        regs_wr_id_out;
  logic [31:0]        regs_data_out;
  logic               err_out;

  regs_wb_arbiter #(.NREQ(NREQ), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .wb_write_in(wb_write_in), .wb_id_in(wb_id_in), .wb_data_in(wb_data_in),
    .req_valid_in(req_valid_in), .req_id_in(req_id_in), .req_data_in(req_data_in),
    .req_ready_out(req_ready_out), .stall_out(stall_out),
    .regs_write_out(regs_write_out), .regs_wr_id_out(regs_wr_id_out),
    .regs_data_out(regs_data_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: registered expectations plus arbitration bookkeeping.
  int          m_ptr = 0;
  int          m_cnt = 0;
  bit          m_force = 0;
  bit          m_err = 0;
  bit          m_wr = 0;
  logic [31:0] m_id = '0;
  logic [31:0] m_data = '0;
  bit          armed = 0;
  logic [NREQ-1:0] last_ready = '0;

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    logic [31:0]     wid;
    int              g;
    int              cand;
    bit              wb_win;
    bit              nf;
    g      = -1;
    wb_win = 0;
    nf     = 0;
    if (!m_force && wb_write_in && wb_id_in != 0) wb_win = 1;
    else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid_in[cand]) g = cand;
      end
    end
    exp_rdy = '0;
    if (reset && g >= 0) exp_rdy = NREQ'(1) << g;
    last_ready = req_ready_out;
    if (armed) begin
      check("ready", 32'(req_ready_out), 32'(exp_rdy));
      check("stall", 32'(stall_out), 32'(m_force));
      check("write", 32'(regs_write_out), 32'(m_wr));
      check("wr_id", regs_wr_id_out, m_id);
      check("data", regs_data_out, m_data);
      check("err", 32'(err_out), 32'(m_err));
    end
    if (!reset) begin
      m_ptr = 0; m_cnt = 0; m_force = 0; m_err = 0;
      m_wr = 0; m_id = '0; m_data = '0; armed = 1;
    end else begin
      if (m_force && (wb_write_in || g < 0)) m_err = 1;
      if (g >= 0) begin
        wid  = req_id_in[32*g +: 32];
        m_wr = (wid != 0);
        if (m_wr) begin
          m_id   = wid;
          m_data = req_data_in[32*g +: 32];
        end
        m_ptr = (g + 1) % NREQ;
        m_cnt = 0;
      end else if (wb_win) begin
        m_wr = 1; m_id = wb_id_in; m_data = wb_data_in;
      end else begin
        m_wr = 0;
      end
      if (!m_force && g < 0 && req_valid_in != 0) begin
        if (m_cnt == LIM - 1) begin
          nf = 1; m_cnt = 0;
        end else m_cnt++;
      end
      m_force = nf;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [31:0] id, input logic [31:0] d);
    req_valid_in[i]       = v;
    req_id_in[32*i +: 32]   = id;
    req_data_in[32*i +: 32] = d;
  endtask

  initial begin
    bit stall_seen;
    // Reset then idle
    reset = 1'b0;
    cyc(); cyc();
    reset = 1'b1;
    stall_seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (stall_out) stall_seen = 1;
    end
    check("idle_stall_never", 32'(stall_seen), 32'd0);
    check("idle_write", 32'(regs_write_out), 32'd0);
    check("idle_id", regs_wr_id_out, 32'd0);

    // Round-robin from pointer 0
    set_req(0, 1, 32'd3, 32'h11);
    set_req(1, 1, 32'd7, 32'h22);
    #1 check("rr_rdy_first", 32'(req_ready_out), 32'b01);
    cyc();
    req_valid_in[0] = 1'b0;
    #1 check("rr_rdy_second", 32'(req_ready_out), 32'b10);
    check("rr_wr0_id", regs_wr_id_out, 32'd3);
    check("rr_wr0_data", regs_data_out, 32'h11);
    cyc();
    req_valid_in[1] = 1'b0;
    check("rr_wr1_id", regs_wr_id_out, 32'd7);
    check("rr_wr1_data", regs_data_out, 32'h22);
    check("rr_wr1_en", 32'(regs_write_out), 32'd1);

    // WB only, then WB to index 0
    wb_write_in = 1'b1; wb_id_in = 32'd5; wb_data_in = 32'hDEADBEEF;
    cyc();
    check("wb_en", 32'(regs_write_out), 32'd1);
    check("wb_id", regs_wr_id_out, 32'd5);
    check("wb_data", regs_data_out, 32'hDEADBEEF);
    wb_id_in = 32'd0; wb_data_in = 32'h12345678;
    cyc();
    check("wb_r0_en", 32'(regs_write_out), 32'd0);
    check("wb_r0_hold", regs_wr_id_out, 32'd5);
    wb_write_in = 1'b0;

    // Starvation: WB every cycle, pipeline honours the stall
    wb_write_in = 1'b1; wb_id_in = 32'd1; wb_data_in = 32'hA5A5;
    set_req(1, 1, 32'd9, 32'h99);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("starve_stall", 32'(stall_out), (k == 4) ? 32'd1 : 32'd0);
      if (stall_out) wb_write_in = 1'b0;
    end
    #1 check("starve_rdy", 32'(req_ready_out), 32'b10);
    cyc();
    req_valid_in[1] = 1'b0;
    check("starve_stall_off", 32'(stall_out), 32'd0);
    check("starve_wr_id", regs_wr_id_out, 32'd9);
    check("starve_err", 32'(err_out), 32'd0);

    // Protocol violation: WB kept during the stall cycle
    wb_write_in = 1'b1; wb_id_in = 32'd2; wb_data_in = 32'hBBBB;
    set_req(1, 1, 32'd10, 32'hCC);
    for (int k = 1; k <= 4; k++) cyc();
    check("viol_stall", 32'(stall_out), 32'd1);
    cyc();
    req_valid_in[1] = 1'b0;
    wb_write_in = 1'b0;
    check("viol_err", 32'(err_out), 32'd1);
    check("viol_late_id", regs_wr_id_out, 32'd10);
    check("viol_late_data", regs_data_out, 32'hCC);
    cyc(); cyc();
    check("viol_err_sticky", 32'(err_out), 32'd1);

    // Reset mid-stream
    reset = 1'b0; cyc(); reset = 1'b1;
    set_req(0, 1, 32'd6, 32'h66);
    cyc();
    req_valid_in[0] = 1'b0;               // pointer now 1
    set_req(0, 1, 32'd6, 32'h67);
    set_req(1, 1, 32'd4, 32'h44);
    reset = 1'b0;
    #1 check("rst_rdy_gated", 32'(req_ready_out), 32'd0);
    cyc();
    reset = 1'b1;
    #1 check("rst_no_write", 32'(regs_write_out), 32'd0);
    check("rst_rr_ptr0", 32'(req_ready_out), 32'b01);
    check("rst_err_clear", 32'(err_out), 32'd0);
    cyc();
    req_valid_in[0] = 1'b0;
    cyc();
    req_valid_in[1] = 1'b0;
    cyc();

    // Randomized traffic with legal handshakes
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_ready[i]) req_valid_in[i] = 1'b0;
        if (!req_valid_in[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1, ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 31)),
                  $urandom);
      end
      wb_write_in = ($urandom_range(0, 9) < 7);
      if (stall_out) wb_write_in = ($urandom_range(0, 49) == 0);
      wb_id_in   = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 31));
      wb_data_in = $urandom;
      reset      = ($urandom_range(0, 199) != 0);
      cyc();
    end
    reset = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
